// File: rtl/scr1_memif.sv
// Shared memory-interface types for the SCR1 data path and the core/RLWE
// data-port arbiter.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

package scr1_memif;

  localparam int unsigned SCR1_VECTOR_WIDTH = 128;

  typedef logic [SCR1_VECTOR_WIDTH-1:0] type_vector;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [2:0] {
    SCR1_MEM_WIDTH_BYTE  = 3'd0,
    SCR1_MEM_WIDTH_HWORD = 3'd1,
    SCR1_MEM_WIDTH_WORD  = 3'd2,
    SCR1_MEM_WIDTH_DWORD = 3'd3,
    SCR1_MEM_WIDTH_VEC   = 3'd4
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'd0,
    SCR1_MEM_RESP_RDY_OK = 2'd1,
    SCR1_MEM_RESP_RDY_ER = 2'd2
  } type_scr1_mem_resp_e;

  typedef enum logic {
    SCR1_ARB_CORE = 1'b0,
    SCR1_ARB_RLWE = 1'b1
  } type_scr1_arb_owner_e;

  typedef enum logic {
    SCR1_ARB_IDLE = 1'b0,
    SCR1_ARB_BUSY = 1'b1
  } type_scr1_arb_st_e;

endpackage

// File: rtl/scr1_arb_starve_cnt.sv
// Saturating count of cycles an RLWE request has been waiting; reaching the
// limit forces the RLWE side to win the next grant.
module scr1_arb_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 8,
  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rlwe_req,
  input  logic rlwe_accept,
  output logic at_limit
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_r;

  // Wait counter: clears when RLWE is served or stops asking, else saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (rlwe_accept | ~rlwe_req) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r != LIMIT) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_limit = (cnt_r == LIMIT);

endmodule

// File: rtl/scr1_dmem_arb.sv
// Core/RLWE arbiter for the single TCM data port: fixed core priority with an
// RLWE anti-starvation bound, one outstanding transaction, owner-routed response.
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

module scr1_dmem_arb
  import scr1_memif::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned AWIDTH       = `SCR1_DMEM_AWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 core_req,
  output logic                 core_req_ack,
  input  type_scr1_mem_cmd_e   core_cmd,
  input  type_scr1_mem_width_e core_width,
  input  logic [AWIDTH-1:0]    core_addr,
  input  type_vector           core_wdata,
  output type_vector           core_rdata,
  output type_scr1_mem_resp_e  core_resp,
  input  logic                 rlwe_req,
  output logic                 rlwe_req_ack,
  input  type_scr1_mem_cmd_e   rlwe_cmd,
  input  type_scr1_mem_width_e rlwe_width,
  input  logic [AWIDTH-1:0]    rlwe_addr,
  input  type_vector           rlwe_wdata,
  output type_vector           rlwe_rdata,
  output type_scr1_mem_resp_e  rlwe_resp,
  output logic                 mem_req,
  input  logic                 mem_req_ack,
  output type_scr1_mem_cmd_e   mem_cmd,
  output type_scr1_mem_width_e mem_width,
  output logic [AWIDTH-1:0]    mem_addr,
  output type_vector           mem_wdata,
  input  type_vector           mem_rdata,
  input  type_scr1_mem_resp_e  mem_resp,
  output logic                 arb_owner
);

  type_scr1_arb_st_e    st_r;
  type_scr1_arb_st_e    st_next_s;
  type_scr1_arb_owner_e owner_r;
  type_scr1_arb_owner_e owner_next_s;
  type_scr1_arb_owner_e sel_owner_s;
  logic                 en_r;
  logic                 resp_done_s;
  logic                 free_s;
  logic                 sel_rlwe_s;
  logic                 accept_s;
  logic                 starve_lim_s;

  // A response in BUSY frees the port in the same cycle, enabling back-to-back
  assign resp_done_s = (mem_resp != SCR1_MEM_RESP_NOTRDY);
  assign free_s      = en_r & ((st_r == SCR1_ARB_IDLE) | resp_done_s);
  assign sel_rlwe_s  = rlwe_req & (~core_req | starve_lim_s);
  assign sel_owner_s = sel_rlwe_s ? SCR1_ARB_RLWE : SCR1_ARB_CORE;
  assign mem_req     = free_s & (core_req | rlwe_req);
  assign accept_s    = mem_req & mem_req_ack;
  assign arb_owner   = (owner_r == SCR1_ARB_RLWE);

  scr1_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) i_starve_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .rlwe_req    (rlwe_req),
    .rlwe_accept (accept_s & sel_rlwe_s),
    .at_limit    (starve_lim_s)
  );

  // State, owner and post-reset enable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r    <= SCR1_ARB_IDLE;
      owner_r <= SCR1_ARB_CORE;
      en_r    <= 1'b0;
    end else begin
      st_r    <= st_next_s;
      owner_r <= owner_next_s;
      en_r    <= 1'b1;
    end
  end

  // Next-state and next-owner selection
  always_comb begin
    st_next_s    = st_r;
    owner_next_s = owner_r;
    case (st_r)
      SCR1_ARB_IDLE: begin
        if (accept_s) begin
          st_next_s    = SCR1_ARB_BUSY;
          owner_next_s = sel_owner_s;
        end else begin
          st_next_s    = SCR1_ARB_IDLE;
        end
      end
      SCR1_ARB_BUSY: begin
        if (accept_s) begin
          st_next_s    = SCR1_ARB_BUSY;
          owner_next_s = sel_owner_s;
        end else if (resp_done_s) begin
          st_next_s    = SCR1_ARB_IDLE;
        end else begin
          st_next_s    = SCR1_ARB_BUSY;
        end
      end
      default: begin
        st_next_s = SCR1_ARB_IDLE;
      end
    endcase
  end

  // Acks, request-field mux and response routing to the registered owner
  always_comb begin
    core_req_ack = 1'b0;
    rlwe_req_ack = 1'b0;
    core_resp    = SCR1_MEM_RESP_NOTRDY;
    rlwe_resp    = SCR1_MEM_RESP_NOTRDY;
    core_rdata   = {SCR1_VECTOR_WIDTH{1'b0}};
    rlwe_rdata   = {SCR1_VECTOR_WIDTH{1'b0}};
    if (accept_s) begin
      core_req_ack = ~sel_rlwe_s;
      rlwe_req_ack = sel_rlwe_s;
    end else begin
      core_req_ack = 1'b0;
      rlwe_req_ack = 1'b0;
    end
    if (sel_rlwe_s) begin
      mem_cmd   = rlwe_cmd;
      mem_width = rlwe_width;
      mem_addr  = rlwe_addr;
      mem_wdata = rlwe_wdata;
    end else begin
      mem_cmd   = core_cmd;
      mem_width = core_width;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
    case (st_r)
      SCR1_ARB_BUSY: begin
        if (owner_r == SCR1_ARB_RLWE) begin
          rlwe_resp  = mem_resp;
          rlwe_rdata = mem_rdata;
        end else begin
          core_resp  = mem_resp;
          core_rdata = mem_rdata;
        end
      end
      default: begin
        core_resp = SCR1_MEM_RESP_NOTRDY;
        rlwe_resp = SCR1_MEM_RESP_NOTRDY;
      end
    endcase
  end

endmodule

// File: tb/tb_scr1_dmem_arb.sv
// Scoreboard bench for scr1_dmem_arb: directed scenarios plus randomized traffic
// against a transaction-level model of the arbitration and routing rules.
module tb_scr1_dmem_arb;
  import scr1_memif::*;

  localparam int unsigned LIM = 4;
  localparam int          AW  = 32;

  typedef struct {
    bit                  owner;
    type_scr1_mem_resp_e resp;
    type_vector          data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_req = 1'b0, rlwe_req = 1'b0, mem_req_ack = 1'b0;
  logic core_req_ack, rlwe_req_ack, mem_req, arb_owner;
  type_scr1_mem_cmd_e   core_cmd = SCR1_MEM_CMD_RD, rlwe_cmd = SCR1_MEM_CMD_RD, mem_cmd;
  type_scr1_mem_width_e core_width = SCR1_MEM_WIDTH_WORD, rlwe_width = SCR1_MEM_WIDTH_WORD, mem_width;
  logic [AW-1:0]        core_addr = '0, rlwe_addr = '0, mem_addr;
  type_vector           core_wdata = '0, rlwe_wdata = '0, mem_wdata;
  type_vector           core_rdata, rlwe_rdata, mem_rdata = '0;
  type_scr1_mem_resp_e  core_resp, rlwe_resp, mem_resp = SCR1_MEM_RESP_NOTRDY;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: enable, outstanding transaction, response countdown, RLWE wait
  bit m_en = 1'b0, m_busy = 1'b0, m_owner = 1'b0;
  int m_wait = 0, m_starve = 0;

  bit            f_addr = 1'b0;
  logic [AW-1:0] f_addr_v = '0;
  bit            f_data = 1'b0;
  type_vector    f_data_v = '0;
  int            f_wait = -1;

  always #5 clk = ~clk;

  scr1_dmem_arb #(.STARVE_LIMIT(LIM), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_req_ack(core_req_ack), .core_cmd(core_cmd),
    .core_width(core_width), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_resp(core_resp),
    .rlwe_req(rlwe_req), .rlwe_req_ack(rlwe_req_ack), .rlwe_cmd(rlwe_cmd),
    .rlwe_width(rlwe_width), .rlwe_addr(rlwe_addr), .rlwe_wdata(rlwe_wdata),
    .rlwe_rdata(rlwe_rdata), .rlwe_resp(rlwe_resp),
    .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_cmd(mem_cmd),
    .mem_width(mem_width), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .arb_owner(arb_owner)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic type_vector rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One bus cycle: drive requests and memory side, check grant, advance the model
  task automatic do_cycle(input bit creq, input bit rreq, input bit mack);
    bit free, e_req, e_rl, acc, responding;
    exp_t e;
    @(negedge clk);
    core_req    = creq;
    rlwe_req    = rreq;
    mem_req_ack = mack;
    core_cmd    = type_scr1_mem_cmd_e'($urandom_range(0, 1));
    rlwe_cmd    = type_scr1_mem_cmd_e'($urandom_range(0, 1));
    core_width  = type_scr1_mem_width_e'($urandom_range(0, 4));
    rlwe_width  = type_scr1_mem_width_e'($urandom_range(0, 4));
    core_addr   = f_addr ? f_addr_v : AW'($urandom);
    rlwe_addr   = AW'($urandom);
    core_wdata  = rnd_vec();
    rlwe_wdata  = rnd_vec();
    responding  = m_busy && (m_wait == 0);
    if (responding) begin
      mem_resp  = ($urandom_range(0, 3) == 0) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
      mem_rdata = f_data ? f_data_v : rnd_vec();
      e.owner = m_owner;
      e.resp  = mem_resp;
      e.data  = mem_rdata;
      exp_q.push_back(e);
    end else if (!m_busy) begin
      // stray response while idle must never be forwarded
      mem_resp  = ($urandom_range(0, 5) == 0) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
      mem_rdata = rnd_vec();
    end else begin
      mem_resp  = SCR1_MEM_RESP_NOTRDY;
      mem_rdata = '0;
    end
    #1;
    free  = m_en && (!m_busy || responding);
    e_req = free && (creq || rreq);
    e_rl  = rreq && (!creq || m_starve == LIM);
    acc   = e_req && mack;
    chk("mem_req", 256'(mem_req), 256'(e_req));
    chk("core_ack", 256'(core_req_ack), 256'(acc && !e_rl));
    chk("rlwe_ack", 256'(rlwe_req_ack), 256'(acc && e_rl));
    chk("arb_owner", 256'(arb_owner), 256'(m_owner));
    if (e_req) begin
      if (e_rl)
        chk("mem_fields", 256'({mem_cmd, mem_width, mem_addr, mem_wdata}),
            256'({rlwe_cmd, rlwe_width, rlwe_addr, rlwe_wdata}));
      else
        chk("mem_fields", 256'({mem_cmd, mem_width, mem_addr, mem_wdata}),
            256'({core_cmd, core_width, core_addr, core_wdata}));
    end
    if (acc) begin
      m_busy  = 1'b1;
      m_owner = e_rl;
      m_wait  = (f_wait >= 0) ? f_wait :
                (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
    end else if (responding) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_wait--;
    end
    if ((acc && e_rl) || !rreq) m_starve = 0;
    else if (m_starve < LIM)    m_starve++;
    m_en = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    core_req = 1'b1; rlwe_req = 1'b1; mem_req_ack = 1'b1;
    mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = rnd_vec();
    m_en = 1'b0; m_busy = 1'b0; m_owner = 1'b0; m_wait = 0; m_starve = 0;
    #1;
    chk("rst_mem_req", 256'(mem_req), 256'(0));
    chk("rst_acks", 256'({core_req_ack, rlwe_req_ack}), 256'(0));
    chk("rst_owner", 256'(arb_owner), 256'(0));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && m_busy; i++) do_cycle(1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: pops the expected response for this cycle, otherwise expects silence
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.owner) begin
          chk("rlwe_rsp", 256'({rlwe_resp, rlwe_rdata}), 256'({e.resp, e.data}));
          chk("core_quiet", 256'({core_resp, core_rdata}), 256'(0));
        end else begin
          chk("core_rsp", 256'({core_resp, core_rdata}), 256'({e.resp, e.data}));
          chk("rlwe_quiet", 256'({rlwe_resp, rlwe_rdata}), 256'(0));
        end
      end else begin
        chk("no_rsp", 256'({core_resp, rlwe_resp, core_rdata}), 256'(0));
        chk("no_rsp_rd", 256'(rlwe_rdata), 256'(0));
      end
    end
  end

  initial begin
    apply_reset();
    do_cycle(1'b1, 1'b1, 1'b1);
    do_cycle(1'b1, 1'b1, 1'b1);
    drain();
    // single core read with a known payload
    f_addr = 1'b1; f_addr_v = 32'h0000_0100;
    f_data = 1'b1; f_data_v = 128'hDEAD_BEEF;
    f_wait = 0;
    do_cycle(1'b1, 1'b0, 1'b1);
    do_cycle(1'b0, 1'b0, 1'b1);
    f_addr = 1'b0; f_data = 1'b0;
    // back-to-back core traffic
    repeat (3) do_cycle(1'b1, 1'b0, 1'b1);
    drain();
    // contention: starvation guard periodically lets RLWE through
    repeat (16) do_cycle(1'b1, 1'b1, 1'b1);
    drain();
    // stall then accept
    repeat (3) do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b1);
    drain();
    // reset while RLWE owns an outstanding transaction
    f_wait = 2;
    do_cycle(1'b0, 1'b1, 1'b1);
    apply_reset();
    f_wait = 0;
    repeat (3) do_cycle(1'b1, 1'b0, 1'b1);
    drain();
    f_wait = -1;
    for (int i = 0; i < 400; i++)
      do_cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0), ($urandom_range(0, 3) != 0));
    drain();
    @(negedge clk);
    #5;
    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
